// File: rtl/spi_cfg_arbiter.sv
// spi_cfg_arbiter
// Shares one spi_master between NUM_CH device configuration FSMs. A channel
// that wins arbitration owns the bus for as many transactions as it likes,
// for as long as it keeps i_req high. Each owner gets its own chip select,
// and read data is steered back with a per-channel valid pulse. A stuck
// spi_busy is broken by a timeout that forces the bus to be released.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   i_req          per-channel level request, held for a whole config burst
//   o_grant        registered one-hot owner indication
//   i_wr_cmd       per-channel write strobe
//   i_rd_cmd       per-channel read strobe
//   i_wr_data      per-channel write words, channel k at [k*MOSI_W +: MOSI_W]
//   o_busy         per-channel busy view
//   o_rd_data      last captured read word
//   o_rd_valid     one-clock pulse to the owner when o_rd_data updates
//   o_spi_wr_cmd   write command to spi_master
//   o_spi_rd_cmd   read command to spi_master
//   o_spi_wr_data  write word to spi_master
//   i_spi_rd_data  read word from spi_master
//   i_spi_busy     spi_master busy
//   i_spi_ncs      spi_master chip select
//   o_cs_n         per-device chip selects, active low, registered
//   o_timeout      one-clock pulse on forced release
module spi_cfg_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int MOSI_W      = 24,
  parameter int MISO_W      = 9,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        i_req,
  output logic [NUM_CH-1:0]        o_grant,
  input  logic [NUM_CH-1:0]        i_wr_cmd,
  input  logic [NUM_CH-1:0]        i_rd_cmd,
  input  logic [NUM_CH*MOSI_W-1:0] i_wr_data,
  output logic [NUM_CH-1:0]        o_busy,
  output logic [MISO_W-1:0]        o_rd_data,
  output logic [NUM_CH-1:0]        o_rd_valid,
  output logic                     o_spi_wr_cmd,
  output logic                     o_spi_rd_cmd,
  output logic [MOSI_W-1:0]        o_spi_wr_data,
  input  logic [MISO_W-1:0]        i_spi_rd_data,
  input  logic                     i_spi_busy,
  input  logic                     i_spi_ncs,
  output logic [NUM_CH-1:0]        o_cs_n,
  output logic                     o_timeout
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  owner, ptr, win_idx, win_next;
  logic              win_found;
  logic [CNT_W-1:0]  tcnt;
  logic              txn_read;
  logic              own_req, own_wr, own_rd;
  logic              accept_wr, accept_rd;
  logic              in_wait, tmo_hit, txn_done;
  logic [NUM_CH-1:0] own_onehot;
  logic [MOSI_W-1:0] own_word;
  int                scan_idx;

  assign own_req    = i_req[owner];
  assign own_wr     = i_wr_cmd[owner];
  assign own_rd     = i_rd_cmd[owner];
  assign own_word   = i_wr_data[owner*MOSI_W +: MOSI_W];
  assign own_onehot = NUM_CH'(1) << owner;
  assign in_wait    = (state == WAIT_HI) || (state == WAIT_LO);
  assign tmo_hit    = in_wait && (tcnt == CNT_LAST);
  // A timeout on the same clock that busy falls still counts as a timeout.
  assign txn_done   = (state == WAIT_LO) && !i_spi_busy && !tmo_hit;
  assign win_next   = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;

  // Winner search: scan from the round-robin pointer (or from 0 in fixed
  // mode) and wrap, taking the first requester found.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = (RR_MODE != 0) ? int'(ptr) + i : i;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      if (!win_found && i_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    o_busy    = '0;
    case (state)
      IDLE:    if (win_found) state_nxt = ISSUE;
      ISSUE: begin
        // Write beats read when both strobe together; the read is dropped.
        accept_wr = own_wr;
        accept_rd = own_rd && !own_wr;
        if (accept_wr || accept_rd) state_nxt = WAIT_HI;
        else if (!own_req)          state_nxt = RELEASE;
      end
      WAIT_HI: begin
        if (tmo_hit)         state_nxt = RELEASE;
        else if (i_spi_busy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (tmo_hit)       state_nxt = RELEASE;
        else if (txn_done) state_nxt = own_req ? ISSUE : RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Everyone but the owner sees busy while the bus is granted; the owner
    // sees it from the clock its command is accepted until completion.
    if ((state == ISSUE) || in_wait) begin
      o_busy = ~o_grant;
      if (in_wait || accept_wr || accept_rd) o_busy = o_busy | o_grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_grant       <= '0;
      owner         <= '0;
      ptr           <= '0;
      o_spi_wr_cmd  <= 1'b0;
      o_spi_rd_cmd  <= 1'b0;
      o_spi_wr_data <= '0;
      o_rd_data     <= '0;
      o_rd_valid    <= '0;
      o_timeout     <= 1'b0;
      o_cs_n        <= '1;
      tcnt          <= '0;
      txn_read      <= 1'b0;
    end else begin
      o_spi_wr_cmd <= accept_wr;
      o_spi_rd_cmd <= accept_rd;
      o_rd_valid   <= '0;
      o_timeout    <= tmo_hit;
      // Only the owner's select follows the master; with no owner all stay high.
      o_cs_n       <= ~o_grant | {NUM_CH{i_spi_ncs}};
      if ((state == IDLE) && win_found) begin
        owner   <= win_idx;
        ptr     <= win_next;
        o_grant <= NUM_CH'(1) << win_idx;
      end
      if ((state != RELEASE) && (state_nxt == RELEASE)) o_grant <= '0;
      if (accept_wr) o_spi_wr_data <= own_word;
      if (accept_wr || accept_rd) begin
        txn_read <= accept_rd;
        tcnt     <= '0;
      end else if (in_wait) begin
        tcnt <= tcnt + 1'b1;
      end
      if (txn_done && txn_read) begin
        o_rd_data  <= i_spi_rd_data;
        o_rd_valid <= own_onehot;
      end
    end
  end

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// tb_spi_cfg_arbiter
// Bench for spi_cfg_arbiter (4 channels, round robin, 16-cycle timeout).
// A behavioural model tracks bus ownership and the transaction in flight
// and predicts every output once per clock; directed scenarios add
// hand-computed expectations, followed by a long randomized run.
module tb_spi_cfg_arbiter;

  localparam int N  = 4;
  localparam int MW = 24;
  localparam int RW = 9;
  localparam int RR = 1;
  localparam int TC = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_req, i_wr_cmd, i_rd_cmd;
  logic [N*MW-1:0] i_wr_data;
  logic [N-1:0]    o_grant, o_busy, o_rd_valid, o_cs_n;
  logic [RW-1:0]   o_rd_data, i_spi_rd_data;
  logic            o_spi_wr_cmd, o_spi_rd_cmd, o_timeout;
  logic [MW-1:0]   o_spi_wr_data;
  logic            i_spi_busy, i_spi_ncs;

  int checks = 0;
  int errors = 0;

  spi_cfg_arbiter #(
    .NUM_CH(N), .MOSI_W(MW), .MISO_W(RW), .RR_MODE(RR), .TIMEOUT_CYC(TC)
  ) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_grant(o_grant),
    .i_wr_cmd(i_wr_cmd), .i_rd_cmd(i_rd_cmd), .i_wr_data(i_wr_data),
    .o_busy(o_busy), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_spi_wr_cmd(o_spi_wr_cmd), .o_spi_rd_cmd(o_spi_rd_cmd),
    .o_spi_wr_data(o_spi_wr_data), .i_spi_rd_data(i_spi_rd_data),
    .i_spi_busy(i_spi_busy), .i_spi_ncs(i_spi_ncs), .o_cs_n(o_cs_n),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner;          // -1 when the bus is free
  int m_stage;          // 0 waiting for a command, 1 waiting busy high, 2 waiting busy low
  int m_age;            // clocks spent waiting on the current transaction
  int m_ptr;            // next round-robin start channel
  bit m_gap;            // one dead clock after a release
  bit m_read;
  logic [N-1:0]  e_grant, e_rd_valid, e_cs_n, e_busy;
  logic          e_wr_cmd, e_rd_cmd, e_timeout;
  logic [MW-1:0] e_wr_data;
  logic [RW-1:0] e_rd_data;

  task automatic model_reset();
    m_owner = -1; m_stage = 0; m_age = 0; m_ptr = 0; m_gap = 0; m_read = 0;
    e_grant = '0; e_rd_valid = '0; e_cs_n = '1;
    e_wr_cmd = 0; e_rd_cmd = 0; e_timeout = 0;
    e_wr_data = '0; e_rd_data = '0;
  endtask

  task automatic release_bus();
    m_owner = -1; m_stage = 0; m_gap = 1; e_grant = '0;
  endtask

  task automatic model_step();
    int start, pick, c;
    logic [N-1:0] g_now;
    g_now = e_grant;
    e_wr_cmd = 0; e_rd_cmd = 0; e_rd_valid = '0; e_timeout = 0;
    if (rst) begin
      model_reset();
      return;
    end
    e_cs_n = ~g_now | {N{i_spi_ncs}};
    if (m_gap) begin
      m_gap = 0;
    end else if (m_owner < 0) begin
      if (i_req != 0) begin
        start = RR ? m_ptr : 0;
        pick = -1;
        for (int i = 0; i < N; i++) begin
          c = (start + i) % N;
          if (pick < 0 && i_req[c]) pick = c;
        end
        m_owner = pick;
        m_ptr = (pick + 1) % N;
        e_grant = N'(1 << pick);
        m_stage = 0;
      end
    end else if (m_stage == 0) begin
      if (i_wr_cmd[m_owner]) begin
        e_wr_cmd = 1; e_wr_data = i_wr_data[m_owner*MW +: MW];
        m_read = 0; m_stage = 1; m_age = 0;
      end else if (i_rd_cmd[m_owner]) begin
        e_rd_cmd = 1; m_read = 1; m_stage = 1; m_age = 0;
      end else if (!i_req[m_owner]) begin
        release_bus();
      end
    end else if (m_age == TC - 1) begin
      e_timeout = 1;
      release_bus();
    end else begin
      if (m_stage == 1) begin
        if (i_spi_busy) m_stage = 2;
      end else if (!i_spi_busy) begin
        if (m_read) begin
          e_rd_data = i_spi_rd_data;
          e_rd_valid = N'(1 << m_owner);
        end
        if (i_req[m_owner]) m_stage = 0;
        else release_bus();
      end
      m_age++;
    end
  endtask

  // Compare process: inputs change just after the rising edge, so at the
  // falling edge both the inputs and the registered outputs are settled.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      chk("grant", 32'(o_grant), 32'(e_grant));
      chk("spi_wr_cmd", 32'(o_spi_wr_cmd), 32'(e_wr_cmd));
      chk("spi_rd_cmd", 32'(o_spi_rd_cmd), 32'(e_rd_cmd));
      chk("spi_wr_data", 32'(o_spi_wr_data), 32'(e_wr_data));
      chk("rd_data", 32'(o_rd_data), 32'(e_rd_data));
      chk("rd_valid", 32'(o_rd_valid), 32'(e_rd_valid));
      chk("cs_n", 32'(o_cs_n), 32'(e_cs_n));
      chk("timeout", 32'(o_timeout), 32'(e_timeout));
      e_busy = '0;
      if (!rst && m_owner >= 0) begin
        e_busy = ~e_grant;
        if (m_stage != 0 || i_wr_cmd[m_owner] || i_rd_cmd[m_owner]) e_busy = '1;
      end
      chk("busy", 32'(o_busy), 32'(e_busy));
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    rst = 1; i_req = '0; i_wr_cmd = '0; i_rd_cmd = '0;
    i_spi_busy = 0; i_spi_ncs = 1;
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic do_wr(input int ch);
    i_wr_cmd[ch] = 1'b1;
    tick();
    i_wr_cmd = '0; i_spi_busy = 1; i_spi_ncs = 0;
    tick();
    i_spi_busy = 0; i_spi_ncs = 1;
    tick();
  endtask

  int gap, got, stuck;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1; i_req = '0; i_wr_cmd = '0; i_rd_cmd = '0;
    i_wr_data = {$urandom, $urandom, $urandom};
    i_spi_rd_data = '0; i_spi_busy = 0; i_spi_ncs = 1;
    tick(); tick();
    chk("reset_cs_n", 32'(o_cs_n), 32'hF);
    chk("reset_grant", 32'(o_grant), 32'h0);
    rst = 0;
    tick();

    // Burst hold: ch0 keeps the bus across three writes while ch2 waits.
    i_req = 4'b0001;
    tick();
    chk("t3_grant0", 32'(o_grant), 32'h1);
    for (int n = 0; n < 3; n++) begin
      if (n == 1) i_req = 4'b0101;
      do_wr(0);
      chk("t3_hold", 32'(o_grant), 32'h1);
    end
    i_req = 4'b0100;
    gap = 0; got = 0;
    for (int w = 0; w < 8 && got == 0; w++) begin
      tick();
      if (o_grant == 0) gap++;
      else got = 1;
    end
    chk("t3_gap", 32'(gap), 32'd2);
    chk("t3_grant2", 32'(o_grant), 32'h4);
    i_req = '0;
    tick(); tick();

    // Single write on ch1, then reset in the middle of the transfer.
    i_wr_data[1*MW +: MW] = 24'h000180;
    i_req = 4'b0010;
    tick();
    chk("t2_grant", 32'(o_grant), 32'h2);
    chk("t2_busy_idle", 32'(o_busy), 32'hD);
    i_wr_cmd = 4'b0010;
    #1 chk("t2_busy_acc", 32'(o_busy), 32'hF);
    tick();
    chk("t2_wr_cmd", 32'(o_spi_wr_cmd), 32'h1);
    chk("t2_wr_data", 32'(o_spi_wr_data), 32'h000180);
    i_wr_cmd = '0; i_spi_busy = 1; i_spi_ncs = 0;
    tick();
    chk("t2_cs_n", 32'(o_cs_n), 32'hD);
    chk("t2_wr_cmd_pulse", 32'(o_spi_wr_cmd), 32'h0);
    #1 rst = 1;
    #1;
    chk("t1_cs_n", 32'(o_cs_n), 32'hF);
    chk("t1_grant", 32'(o_grant), 32'h0);
    chk("t1_cmds", 32'({o_spi_wr_cmd, o_spi_rd_cmd}), 32'h0);
    i_spi_busy = 0; i_spi_ncs = 1; i_req = '0;
    tick(); tick();
    rst = 0;
    tick();

    // Read on ch3, then simultaneous write+read.
    i_req = 4'b1000;
    tick();
    chk("t5_grant", 32'(o_grant), 32'h8);
    i_rd_cmd = 4'b1000;
    tick();
    chk("t5_rd_cmd", 32'(o_spi_rd_cmd), 32'h1);
    chk("t5_no_wr", 32'(o_spi_wr_cmd), 32'h0);
    i_rd_cmd = '0; i_spi_busy = 1; i_spi_ncs = 0;
    tick();
    chk("t5_valid_early", 32'(o_rd_valid), 32'h0);
    i_spi_busy = 0; i_spi_ncs = 1; i_spi_rd_data = 9'h0A5;
    tick();
    chk("t5_rd_data", 32'(o_rd_data), 32'h0A5);
    chk("t5_rd_valid", 32'(o_rd_valid), 32'h8);
    i_spi_rd_data = 9'h155;
    tick();
    chk("t5_valid_pulse", 32'(o_rd_valid), 32'h0);
    i_wr_data[3*MW +: MW] = 24'hABCDEF;
    i_wr_cmd = 4'b1000; i_rd_cmd = 4'b1000;
    tick();
    chk("t5_both_wr", 32'(o_spi_wr_cmd), 32'h1);
    chk("t5_both_rd", 32'(o_spi_rd_cmd), 32'h0);
    chk("t5_both_data", 32'(o_spi_wr_data), 32'hABCDEF);
    i_wr_cmd = '0; i_rd_cmd = '0; i_spi_busy = 1;
    tick();
    i_spi_busy = 0;
    tick();
    chk("t5_wr_no_valid", 32'(o_rd_valid), 32'h0);
    chk("t5_rd_data_kept", 32'(o_rd_data), 32'h0A5);
    i_req = '0;
    tick();
    chk("t5_released", 32'(o_grant), 32'h0);
    tick();

    // Timeout: busy stuck high after a write on ch0.
    i_req = 4'b0001;
    tick();
    chk("t6_grant", 32'(o_grant), 32'h1);
    i_wr_cmd = 4'b0001;
    tick();
    i_wr_cmd = '0; i_spi_busy = 1; i_spi_ncs = 0;
    for (int k = 0; k < 15; k++) tick();
    chk("t6_not_yet", 32'(o_timeout), 32'h0);
    tick();
    chk("t6_timeout", 32'(o_timeout), 32'h1);
    chk("t6_grant_off", 32'(o_grant), 32'h0);
    chk("t6_no_valid", 32'(o_rd_valid), 32'h0);
    tick();
    chk("t6_pulse", 32'(o_timeout), 32'h0);
    i_spi_busy = 0; i_spi_ncs = 1; i_req = '0;
    tick(); tick();

    // Round robin: all four request, each does one write and drops.
    reset_pulse();
    i_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      got = 0;
      for (int w = 0; w < 6 && got == 0; w++) begin
        tick();
        if (o_grant != 0) got = 1;
      end
      chk("t4_order", 32'(o_grant), 32'(1) << order[n]);
      i_wr_cmd[order[n]] = 1'b1;
      tick();
      i_wr_cmd = '0; i_req[order[n]] = 1'b0; i_spi_busy = 1;
      tick();
      i_spi_busy = 0;
      tick();
      i_req = 4'b1111;
    end
    i_req = '0;
    tick(); tick(); tick();

    // Randomized traffic, model-checked every clock.
    stuck = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 599) == 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) i_req[k] = ~i_req[k];
        i_wr_cmd[k] = ($urandom_range(0, 3) == 0);
        i_rd_cmd[k] = ($urandom_range(0, 3) == 0);
      end
      i_wr_data = {$urandom, $urandom, $urandom};
      if (stuck > 0) stuck--;
      else if ($urandom_range(0, 99) == 0) begin
        stuck = 20;
        i_spi_busy = 1;
      end else if ($urandom_range(0, 2) == 0) i_spi_busy = ~i_spi_busy;
      i_spi_ncs = 1'($urandom_range(0, 1));
      i_spi_rd_data = RW'($urandom);
    end
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
